sprite_plotter: RTL and testbench

Parametrised sprite-drawing engine that walks a SPR_W x SPR_H sprite stored in an external ROM and emits one pixel per clock (x, y, colour, plot) to the VGA adapter. It is the generalised successor of the per-object plot FSMs (user, alien, bullet): one instance serves any sprite size or colour depth. It adds a start/busy/done handshake, configurable ROM read latency, a transparent colour key, an erase mode, and screen-edge clipping.

---
 rtl/sprite_plotter.sv | 166 ++++++++++++++++
 tb/tb_sprite_plotter.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_plotter.sv
// Sprite drawing engine: walks a SPR_W x SPR_H sprite ROM and emits one
// clipped, colour-keyed pixel per clock to the VGA adapter.
module sprite_plotter #(
  parameter int SPR_W       = 20,
  parameter int SPR_H       = 20,
  parameter int ADDR_W      = 10,
  parameter int X_W         = 9,
  parameter int Y_W         = 8,
  parameter int COL_W       = 3,
  parameter int ROM_LAT     = 1,
  parameter int TRANSPARENT = 0,
  parameter int SCREEN_W    = 320,
  parameter int SCREEN_H    = 240
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              erase,
  input  logic [X_W-1:0]    x_origin,
  input  logic [Y_W-1:0]    y_origin,
  input  logic [COL_W-1:0]  bg_colour,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [COL_W-1:0]  rom_q,
  output logic              busy,
  output logic              done,
  output logic [X_W-1:0]    x,
  output logic [Y_W-1:0]    y,
  output logic [COL_W-1:0]  colour,
  output logic              plot
);

  localparam int SX_W = (SPR_W > 1) ? $clog2(SPR_W) : 1;
  localparam int SY_W = (SPR_H > 1) ? $clog2(SPR_H) : 1;
  localparam int DC_W = $clog2(ROM_LAT + 2);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(SPR_W * SPR_H - 1);
  localparam logic [SX_W-1:0]   LAST_SX   = SX_W'(SPR_W - 1);
  localparam logic [DC_W-1:0]   LAST_DC   = DC_W'(ROM_LAT);
  localparam logic [X_W:0]      SCR_W     = (X_W + 1)'(SCREEN_W);
  localparam logic [Y_W:0]      SCR_H     = (Y_W + 1)'(SCREEN_H);
  localparam logic [COL_W-1:0]  KEY       = COL_W'(TRANSPARENT);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t             state;
  logic [X_W-1:0]     x_org;
  logic [Y_W-1:0]     y_org;
  logic               ers;
  logic [COL_W-1:0]   bg;
  logic [ADDR_W-1:0]  addr;
  logic [SX_W-1:0]    sx;
  logic [SY_W-1:0]    sy;
  logic [DC_W-1:0]    dcnt;

  logic               p_v  [ROM_LAT];
  logic [SX_W-1:0]    p_sx [ROM_LAT];
  logic [SY_W-1:0]    p_sy [ROM_LAT];

  logic [X_W:0]       x_sum;
  logic [Y_W:0]       y_sum;

  assign rom_addr = (state == S_FETCH) ? addr : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      x_org <= '0;
      y_org <= '0;
      ers   <= 1'b0;
      bg    <= '0;
      addr  <= '0;
      sx    <= '0;
      sy    <= '0;
      dcnt  <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (start) begin
            x_org <= x_origin;
            y_org <= y_origin;
            ers   <= erase;
            bg    <= bg_colour;
            addr  <= '0;
            sx    <= '0;
            sy    <= '0;
            busy  <= 1'b1;
            state <= S_FETCH;
          end
        end
        S_FETCH: begin
          addr <= addr + 1'b1;
          if (sx == LAST_SX) begin
            sx <= '0;
            sy <= sy + 1'b1;
          end else begin
            sx <= sx + 1'b1;
          end
          if (addr == LAST_ADDR) begin
            dcnt  <= '0;
            state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (dcnt == LAST_DC) begin
            done  <= 1'b1;
            state <= S_DONE;
          end else begin
            dcnt <= dcnt + 1'b1;
          end
        end
        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Coordinates travel alongside the ROM read so they meet rom_q at the head.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < ROM_LAT; i++) begin
        p_v[i]  <= 1'b0;
        p_sx[i] <= '0;
        p_sy[i] <= '0;
      end
    end else begin
      p_v[0]  <= (state == S_FETCH);
      p_sx[0] <= sx;
      p_sy[0] <= sy;
      for (int i = 1; i < ROM_LAT; i++) begin
        p_v[i]  <= p_v[i-1];
        p_sx[i] <= p_sx[i-1];
        p_sy[i] <= p_sy[i-1];
      end
    end
  end

  assign x_sum = {1'b0, x_org} + (X_W + 1)'(p_sx[ROM_LAT-1]);
  assign y_sum = {1'b0, y_org} + (Y_W + 1)'(p_sy[ROM_LAT-1]);

  always_ff @(posedge clk) begin
    if (reset) begin
      x      <= '0;
      y      <= '0;
      colour <= '0;
      plot   <= 1'b0;
    end else begin
      x      <= x_sum[X_W-1:0];
      y      <= y_sum[Y_W-1:0];
      colour <= ers ? bg : rom_q;
      plot   <= p_v[ROM_LAT-1] & (ers | (rom_q != KEY))
              & (x_sum < SCR_W) & (y_sum < SCR_H);
    end
  end

endmodule

// File: tb/tb_sprite_plotter.sv
// Randomised bench for sprite_plotter: default-latency and 3-cycle-latency
// instances compared against a pixel-list reference model.
module tb_sprite_plotter;

  localparam int W = 20;
  localparam int H = 20;
  localparam int N = W * H;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, start1, start3, erase;
  logic [8:0] x_origin;
  logic [7:0] y_origin;
  logic [2:0] bg_colour;

  logic [9:0] addr1, addr3;
  logic [2:0] q1, q3;
  logic       busy1, done1, plot1, busy3, done3, plot3;
  logic [8:0] x1, x3;
  logic [7:0] y1, y3;
  logic [2:0] col1, col3;

  sprite_plotter dut1 (
    .clk(clk), .reset(reset), .start(start1), .erase(erase),
    .x_origin(x_origin), .y_origin(y_origin), .bg_colour(bg_colour),
    .rom_addr(addr1), .rom_q(q1), .busy(busy1), .done(done1),
    .x(x1), .y(y1), .colour(col1), .plot(plot1)
  );

  sprite_plotter #(.ROM_LAT(3)) dut3 (
    .clk(clk), .reset(reset), .start(start3), .erase(erase),
    .x_origin(x_origin), .y_origin(y_origin), .bg_colour(bg_colour),
    .rom_addr(addr3), .rom_q(q3), .busy(busy3), .done(done3),
    .x(x3), .y(y3), .colour(col3), .plot(plot3)
  );

  logic [2:0] rom [1024];
  logic [2:0] q3p [3];

  always @(posedge clk) begin
    q1     <= rom[addr1];
    q3p[0] <= rom[addr3];
    q3p[1] <= q3p[0];
    q3p[2] <= q3p[1];
  end
  assign q3 = q3p[2];

  logic       sel;
  logic       m_busy, m_done, m_plot;
  logic [9:0] m_addr;
  logic [8:0] m_x;
  logic [7:0] m_y;
  logic [2:0] m_col;

  assign m_busy = sel ? busy3 : busy1;
  assign m_done = sel ? done3 : done1;
  assign m_plot = sel ? plot3 : plot1;
  assign m_addr = sel ? addr3 : addr1;
  assign m_x    = sel ? x3 : x1;
  assign m_y    = sel ? y3 : y1;
  assign m_col  = sel ? col3 : col1;

  int vectors = 0;
  int miscompares = 0;

  logic [63:0] expq [$];
  logic [63:0] obsq [$];

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Expected plot list: {cycle after FETCH entry, x, y, colour} per pixel.
  task automatic model(input int lat, input logic [8:0] xo,
                       input logic [7:0] yo, input logic er,
                       input logic [2:0] bg);
    int xs, ys;
    logic [15:0] t;
    logic [8:0] xl;
    logic [7:0] yl;
    logic [2:0] c;
    expq.delete();
    for (int k = 0; k < N; k++) begin
      xs = int'(xo) + k % W;
      ys = int'(yo) + k / W;
      c  = er ? bg : rom[k];
      t  = 16'(k + lat + 1);
      xl = xs[8:0];
      yl = ys[7:0];
      if ((er || rom[k] != 3'd0) && xs < 320 && ys < 240)
        expq.push_back({28'd0, t, xl, yl, c});
    end
  endtask

  task automatic fill(input int mode);
    for (int k = 0; k < 1024; k++)
      case (mode)
        0: rom[k] = 3'd5;
        1: rom[k] = 3'(k % 8);
        default: rom[k] = 3'($urandom);
      endcase
  endtask

  task automatic draw(input logic s, input logic [8:0] xo,
                      input logic [7:0] yo, input logic er,
                      input logic [2:0] bg, input logic hold,
                      input int abort_c);
    int lat, c, busy_cnt, done_c, done_cnt, nexp;
    logic fin;
    logic [15:0] tc;
    sel = s;
    lat = s ? 3 : 1;
    model(lat, xo, yo, er, bg);
    obsq.delete();
    @(negedge clk);
    x_origin  = xo;
    y_origin  = yo;
    erase     = er;
    bg_colour = bg;
    if (s) start3 = 1'b1;
    else   start1 = 1'b1;
    @(negedge clk);
    if (!hold) begin
      start1 = 1'b0;
      start3 = 1'b0;
    end
    c = 0; busy_cnt = 0; done_c = -1; done_cnt = 0; fin = 1'b0;
    while (!fin && c < 1000) begin
      if (c == 5)     check("addr5", m_addr, 64'd5);
      if (c == N - 1) check("addr_last", m_addr, 64'(N - 1));
      if (c == N)     check("addr_idle", m_addr, 64'd0);
      tc = 16'(c);
      if (m_plot) obsq.push_back({28'd0, tc, m_x, m_y, m_col});
      if (m_busy) busy_cnt++;
      if (m_done) begin
        done_cnt++;
        if (done_c < 0) done_c = c;
      end
      if (c == abort_c) begin
        reset = 1'b1;
        @(negedge clk);
        check("rst_plot", m_plot, 64'd0);
        check("rst_busy", m_busy, 64'd0);
        check("rst_addr", m_addr, 64'd0);
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
          @(negedge clk);
          check("rst_quiet", {m_plot, m_busy}, 64'd0);
        end
        nexp = 0;
        foreach (expq[i]) if (int'(expq[i][35:20]) <= abort_c) nexp++;
        check("abort_npix", obsq.size(), nexp);
        for (int i = 0; i < obsq.size() && i < expq.size(); i++)
          check("abort_pix", obsq[i], expq[i]);
        return;
      end
      if (done_c >= 0 && !m_busy) fin = 1'b1;
      else begin
        @(negedge clk);
        c++;
      end
    end
    check("timeout", fin, 64'd1);
    check("busy_len", busy_cnt, 64'(N + lat + 2));
    check("done_cyc", done_c, 64'(N + lat + 1));
    check("done_cnt", done_cnt, 64'd1);
    check("npix", obsq.size(), expq.size());
    for (int i = 0; i < obsq.size() && i < expq.size(); i++)
      check("pix", obsq[i], expq[i]);
    if (hold) begin
      @(negedge clk);
      check("restart", m_busy, 64'd1);
      start1 = 1'b0;
      start3 = 1'b0;
      c = 0;
      while (!m_done && c < 1000) begin
        @(negedge clk);
        c++;
      end
      check("redone", m_done, 64'd1);
      @(negedge clk);
    end
  endtask

  initial begin
    reset = 1'b1; start1 = 1'b0; start3 = 1'b0; erase = 1'b0;
    x_origin = '0; y_origin = '0; bg_colour = '0; sel = 1'b0;
    fill(0);
    repeat (3) @(negedge clk);
    check("rst_busy1", busy1, 64'd0);
    check("rst_done1", done1, 64'd0);
    check("rst_plot1", plot1, 64'd0);
    check("rst_xyc1", {x1, y1, col1}, 64'd0);
    check("rst_addr1", addr1, 64'd0);
    check("rst_busy3", {busy3, done3, plot3}, 64'd0);
    reset = 1'b0;
    @(negedge clk);

    draw(1'b0, 9'd100, 8'd50, 1'b0, 3'd0, 1'b0, -1);
    fill(1);
    draw(1'b0, 9'd100, 8'd50, 1'b0, 3'd0, 1'b0, -1);
    draw(1'b0, 9'd100, 8'd50, 1'b1, 3'd3, 1'b0, -1);
    fill(0);
    draw(1'b0, 9'd310, 8'd230, 1'b0, 3'd0, 1'b0, -1);
    draw(1'b0, 9'd500, 8'd10, 1'b0, 3'd0, 1'b0, -1);
    for (int i = 0; i < 4; i++) begin
      fill(2);
      draw(1'b0, 9'($urandom), 8'($urandom), 1'($urandom),
           3'($urandom), 1'b0, -1);
    end
    for (int i = 0; i < 2; i++) begin
      fill(2);
      draw(1'b1, 9'($urandom_range(0, 319)), 8'($urandom_range(0, 239)),
           1'($urandom), 3'($urandom), 1'b0, -1);
    end
    fill(1);
    draw(1'b0, 9'd40, 8'd20, 1'b0, 3'd0, 1'b1, -1);
    draw(1'b0, 9'd100, 8'd50, 1'b0, 3'd0, 1'b0, 202);
    fill(2);
    draw(1'b0, 9'd305, 8'd225, 1'b0, 3'd0, 1'b0, -1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
